boid_frame_sequencer: RTL and testbench

BOID_FRAME_SEQUENCER -- requirements
Module: boid_frame_sequencer

---
 rtl/boid_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_boid_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_sequencer.sv
// Frame sequencer for a boid renderer: clears/swaps the display buffer, then sweeps every boid
// once and turns on-screen, enabled boids into framebuffer pixel writes.
module boid_frame_sequencer #(
  parameter int unsigned NUM_BOIDS = 64,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned IDX_W     = $clog2(NUM_BOIDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 refresh,
  input  logic [NUM_BOIDS-1:0] boid_mask,
  input  logic [X_W-1:0]       boid_x,
  input  logic [Y_W-1:0]       boid_y,
  output logic [IDX_W-1:0]     boid_idx,
  output logic                 fb_we,
  output logic [ADDR_W-1:0]    fb_addr,
  output logic                 fb_clear,
  output logic                 buf_sel,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          clip_count,
  output logic [7:0]           drop_count
);

  typedef enum logic [1:0] {StIdle, StClear, StSweep, StFlush} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               buf_q, buf_d;
  logic               pending_q, pending_d;
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        clip_q, clip_d;
  logic [7:0]         drop_q, drop_d;

  logic               last_idx;
  logic               in_view;
  logic               enabled;
  logic [31:0]        addr_full;
  logic               unused_addr_hi;

  // Full-width address first; only the low ADDR_W bits reach the framebuffer.
  assign addr_full      = 32'(boid_x) + SCREEN_W * 32'(boid_y);
  assign unused_addr_hi = ^addr_full[31:ADDR_W];

  assign last_idx = (idx_q == IDX_W'(NUM_BOIDS - 1));
  assign in_view  = (32'(boid_x) < SCREEN_W) && (32'(boid_y) < SCREEN_H);
  assign enabled  = boid_mask[idx_q];

  always_comb begin
    state_d   = state_q;
    idx_d     = '0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    buf_d     = buf_q;
    pending_d = pending_q;
    acc_d     = acc_q;
    clip_d    = clip_q;
    drop_d    = drop_q;

    case (state_q)
      StIdle:  if (refresh || pending_q) state_d = StClear;
      StClear: state_d = StSweep;
      StSweep: if (last_idx) state_d = StFlush;
      StFlush: state_d = pending_q ? StClear : StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q == StSweep) begin
      if (!last_idx) idx_d = idx_q + IDX_W'(1);
      if (enabled && in_view) begin
        we_d   = 1'b1;
        addr_d = addr_full[ADDR_W-1:0];
      end else if (enabled && acc_q != 16'hFFFF) begin
        acc_d = acc_q + 16'd1;
      end
    end

    if (state_q == StFlush) begin
      clip_d = acc_q;
      acc_d  = '0;
    end

    // One request may queue behind a running sweep; any further ones are counted as dropped.
    if (refresh) begin
      if (pending_q) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else if (state_q != StIdle) begin
        pending_d = 1'b1;
      end
    end

    if (state_d == StClear) begin
      pending_d = 1'b0;
      buf_d     = ~buf_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      buf_q     <= 1'b0;
      pending_q <= 1'b0;
      acc_q     <= '0;
      clip_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
      clip_q    <= clip_d;
      drop_q    <= drop_d;
    end
  end

  assign boid_idx   = idx_q;
  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_clear   = (state_q == StClear);
  assign buf_sel    = buf_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFlush);
  assign clip_count = clip_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Bench for boid_frame_sequencer: directed sweep table, randomized sweeps against a
// per-boid reference model, and hand-written refresh/reset sequences.
module tb_boid_frame_sequencer;
  localparam int N  = 4;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = 19;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          refresh;
  logic [N-1:0]  boid_mask;
  logic [XW-1:0] boid_x;
  logic [YW-1:0] boid_y;
  logic [IW-1:0] boid_idx;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic          fb_clear;
  logic          buf_sel;
  logic          busy;
  logic          done;
  logic [15:0]   clip_count;
  logic [7:0]    drop_count;

  logic [XW-1:0] bx [N];
  logic [YW-1:0] by [N];

  assign boid_x = bx[boid_idx];
  assign boid_y = by[boid_idx];

  always #5 clock = ~clock;

  boid_frame_sequencer #(
    .NUM_BOIDS(N), .SCREEN_W(SW), .SCREEN_H(SH), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .IDX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .refresh(refresh), .boid_mask(boid_mask),
    .boid_x(boid_x), .boid_y(boid_y), .boid_idx(boid_idx), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_clear(fb_clear), .buf_sel(buf_sel), .busy(busy), .done(done),
    .clip_count(clip_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [N-1:0]         mask;
    logic [N-1:0][XW-1:0] x;
    logic [N-1:0][YW-1:0] y;
    logic [N-1:0]         exp_we;
    logic [N-1:0][AW-1:0] exp_addr;
    logic [15:0]          exp_clip;
  } vec_t;

  vec_t          tbl [5];
  int            errors = 0;
  int            checks = 0;
  logic          model_buf;
  logic [AW-1:0] model_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s wait_idle: busy still 1 after %0d cycles, expected 0", tag, bound);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " fb_we"}, 32'(fb_we), 0);
    chk({tag, " fb_clear"}, 32'(fb_clear), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " boid_idx"}, 32'(boid_idx), 0);
    chk({tag, " fb_addr"}, 32'(fb_addr), 0);
    chk({tag, " buf_sel"}, 32'(buf_sel), 0);
    chk({tag, " clip_count"}, 32'(clip_count), 0);
    chk({tag, " drop_count"}, 32'(drop_count), 0);
  endtask

  task automatic load_boids(input vec_t v);
    for (int i = 0; i < N; i++) begin
      bx[i] = v.x[i];
      by[i] = v.y[i];
    end
    boid_mask = v.mask;
  endtask

  // One full sweep from IDLE, checked cycle by cycle against the documented frame timeline.
  task automatic do_sweep(input vec_t v, input string tag);
    logic e_we;
    load_boids(v);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    model_buf = ~model_buf;
    for (int k = 1; k <= N + 3; k++) begin
      e_we = (k >= 3 && k <= N + 2) ? v.exp_we[k-3] : 1'b0;
      if (e_we) model_addr = v.exp_addr[k-3];
      chk($sformatf("%s k%0d fb_clear", tag, k), 32'(fb_clear), 32'(k == 1));
      chk($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'(k <= N + 2));
      chk($sformatf("%s k%0d done", tag, k), 32'(done), 32'(k == N + 2));
      chk($sformatf("%s k%0d boid_idx", tag, k), 32'(boid_idx),
          (k >= 2 && k <= N + 1) ? 32'(k - 2) : 32'd0);
      chk($sformatf("%s k%0d fb_we", tag, k), 32'(fb_we), 32'(e_we));
      chk($sformatf("%s k%0d fb_addr", tag, k), 32'(fb_addr), 32'(model_addr));
      chk($sformatf("%s k%0d buf_sel", tag, k), 32'(buf_sel), 32'(model_buf));
      if (k < N + 3) tick();
    end
    chk({tag, " clip_count"}, 32'(clip_count), 32'(v.exp_clip));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   rclip;
    int   clears;
    logic b0;

    tbl[0].mask = 4'b1111; tbl[0].exp_we = 4'b1111; tbl[0].exp_clip = 16'd0;
    tbl[0].x = {10'd639, 10'd0, 10'd1, 10'd0};
    tbl[0].y = {9'd479, 9'd1, 9'd0, 9'd0};
    tbl[0].exp_addr = {19'd307199, 19'd640, 19'd1, 19'd0};
    tbl[1].mask = 4'b1101; tbl[1].exp_we = 4'b1001; tbl[1].exp_clip = 16'd1;
    tbl[1].x = {10'd639, 10'd640, 10'd1, 10'd0};
    tbl[1].y = {9'd479, 9'd5, 9'd0, 9'd0};
    tbl[1].exp_addr = {19'd307199, 19'd0, 19'd0, 19'd0};
    tbl[2].mask = 4'b0000; tbl[2].exp_we = 4'b0000; tbl[2].exp_clip = 16'd0;
    tbl[2].x = {10'd1023, 10'd1023, 10'd1023, 10'd1023};
    tbl[2].y = {9'd511, 9'd511, 9'd511, 9'd511};
    tbl[2].exp_addr = '0;
    tbl[3].mask = 4'b1111; tbl[3].exp_we = 4'b0011; tbl[3].exp_clip = 16'd2;
    tbl[3].x = {10'd0, 10'd640, 10'd0, 10'd639};
    tbl[3].y = {9'd480, 9'd0, 9'd479, 9'd0};
    tbl[3].exp_addr = {19'd0, 19'd0, 19'd306560, 19'd639};
    tbl[4].mask = 4'b1010; tbl[4].exp_we = 4'b0010; tbl[4].exp_clip = 16'd1;
    tbl[4].x = {10'd700, 10'd3, 10'd5, 10'd1000};
    tbl[4].y = {9'd100, 9'd3, 9'd2, 9'd0};
    tbl[4].exp_addr = {19'd0, 19'd0, 19'd1285, 19'd0};

    reset = 1'b1; refresh = 1'b0; boid_mask = '0;
    for (int i = 0; i < N; i++) begin bx[i] = '0; by[i] = '0; end
    tick();
    refresh = 1'b1;
    tick();
    check_reset_vals("reset");
    reset = 1'b0; refresh = 1'b0;
    tick();
    chk("post-reset busy", 32'(busy), 0);
    model_buf = 1'b0;
    model_addr = '0;

    for (int t = 0; t < 5; t++) do_sweep(tbl[t], $sformatf("vec%0d", t));

    // Randomized boid positions and masks; expectations from the per-boid draw/clip rules.
    for (int r = 0; r < 20; r++) begin
      rclip = 0;
      rv.mask = N'($urandom);
      for (int i = 0; i < N; i++) begin
        rv.x[i] = ($urandom_range(3, 0) == 0) ? XW'(638 + $urandom_range(3, 0)) : XW'($urandom);
        rv.y[i] = ($urandom_range(3, 0) == 0) ? YW'(478 + $urandom_range(3, 0)) : YW'($urandom);
        rv.exp_we[i] = rv.mask[i] && (int'(rv.x[i]) < SW) && (int'(rv.y[i]) < SH);
        rv.exp_addr[i] = AW'(int'(rv.x[i]) + SW * int'(rv.y[i]));
        if (rv.mask[i] && !rv.exp_we[i]) rclip++;
      end
      rv.exp_clip = 16'(rclip);
      do_sweep(rv, $sformatf("rand%0d", r));
      for (int g = $urandom_range(3, 0); g > 0; g--) tick();
    end

    // Second request mid-sweep queues exactly one follow-on sweep.
    load_boids(tbl[0]);
    b0 = buf_sel;
    refresh = 1'b1; tick(); refresh = 1'b0;
    tick(); tick();
    refresh = 1'b1; tick(); refresh = 1'b0;
    tick(); tick();
    chk("b2b T0+6 done", 32'(done), 1);
    tick();
    chk("b2b T0+7 fb_clear", 32'(fb_clear), 1);
    wait_idle(20, "b2b");
    chk("b2b buf_sel", 32'(buf_sel), 32'(b0));
    chk("b2b drop_count", 32'(drop_count), 0);

    // Request during FLUSH is held as pending: one IDLE cycle, then CLEAR.
    refresh = 1'b1; tick(); refresh = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("flushreq T0+6 done", 32'(done), 1);
    refresh = 1'b1; tick(); refresh = 1'b0;
    chk("flushreq T0+7 busy", 32'(busy), 0);
    tick();
    chk("flushreq T0+8 fb_clear", 32'(fb_clear), 1);
    wait_idle(20, "flushreq");

    // Three extra pulses in one sweep: one queued sweep, two drops.
    clears = 0;
    for (int c = 0; c < 26; c++) begin
      refresh = (c == 0 || c == 1 || c == 3 || c == 5);
      tick();
      refresh = 1'b0;
      if (fb_clear) clears++;
    end
    chk("ovf clear pulses", 32'(clears), 2);
    chk("ovf drop_count", 32'(drop_count), 2);
    chk("ovf busy", 32'(busy), 0);

    refresh = 1'b1;
    for (int c = 0; c < 400; c++) tick();
    refresh = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    chk("sat drop_count", 32'(drop_count), 255);
    chk("sat busy", 32'(busy), 0);

    // Reset mid-sweep aborts everything; the next refresh performs a full sweep.
    refresh = 1'b1; tick(); refresh = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_vals("midreset");
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("midreset c%0d fb_we", c), 32'(fb_we), 0);
      chk($sformatf("midreset c%0d done", c), 32'(done), 0);
      chk($sformatf("midreset c%0d busy", c), 32'(busy), 0);
    end
    model_buf = 1'b0;
    model_addr = '0;
    do_sweep(tbl[0], "after-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
